// File: rtl/sram_mem.sv
// sram_mem: 16K x 36 static memory module on the PDP-10 style memory bus.
// A cycle is accepted in IDLE and acknowledged with a single-cycle addr_ack.
// Reads present data with rd_rs a fixed RD_DLY cycles after addr_ack.
// Writes wait for wr_rs, and read-modify-write performs both in order.
// DONE holds until rq_cyc drops, so a request held high is serviced only once.
// Optional feature macro: SRAM_TIMEOUT_EN. When it is defined, a write that
// never receives wr_rs gives up after 1024 cycles without writing anything.
module sram_mem #(
  parameter logic [3:0] SEL    = 4'o0,
  parameter int         RD_DLY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         power,
  input  logic         membus_rq_cyc,
  input  logic         membus_rd_rq,
  input  logic         membus_wr_rq,
  input  logic [21:35] membus_ma,
  input  logic [18:21] membus_sel,
  input  logic         membus_fmc_select,
  input  logic         membus_wr_rs,
  input  logic [0:35]  membus_mb_in,
  output logic [0:35]  membus_mb_out,
  output logic         membus_addr_ack,
  output logic         membus_rd_rs
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACK    = 3'd1,
    RDWAIT = 3'd2,
    RDHOLD = 3'd3,
    WRWAIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  // The read delay counter spans the ACK cycle plus the RDWAIT cycles, so
  // rd_rs rises exactly RD_DLY cycles after addr_ack rises.
  localparam logic [3:0] RD_CNT = 4'(RD_DLY);

  state_t      state_r;
  logic [13:0] addr_r;
  logic        rd_r;
  logic        wr_r;
  logic [3:0]  cnt_r;
  logic        req_s;
  logic        we_s;
  logic [0:35] core [0:16383];

  // Bit 21 of the word address is outside this module's 16K range.
  logic        unused_ma_s;
  assign unused_ma_s = membus_ma[21];

`ifdef SRAM_TIMEOUT_EN
  logic [9:0]  tmo_r;
`endif

  // Request qualification and storage write strobe
  always_comb begin
    req_s = membus_rq_cyc & power & (membus_sel == SEL) & ~membus_fmc_select
          & (membus_rd_rq | membus_wr_rq);
    we_s  = (state_r == WRWAIT) & membus_wr_rs;
  end

  // Storage write port; contents are never cleared by reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      core[addr_r] <= membus_mb_in;
    end
  end

  // Bus cycle sequencer with registered handshake and data outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      addr_r          <= 14'd0;
      rd_r            <= 1'b0;
      wr_r            <= 1'b0;
      cnt_r           <= 4'd0;
      membus_addr_ack <= 1'b0;
      membus_rd_rs    <= 1'b0;
      membus_mb_out   <= 36'o0;
`ifdef SRAM_TIMEOUT_EN
      tmo_r           <= 10'd0;
`endif
    end else begin
      membus_addr_ack <= 1'b0;
      membus_rd_rs    <= 1'b0;
      membus_mb_out   <= 36'o0;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            addr_r          <= membus_ma[22:35];
            rd_r            <= membus_rd_rq;
            wr_r            <= membus_wr_rq;
            cnt_r           <= RD_CNT;
            membus_addr_ack <= 1'b1;
            state_r         <= ACK;
`ifdef SRAM_TIMEOUT_EN
            tmo_r           <= 10'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        ACK: begin
          if (rd_r) begin
            // With RD_DLY=1 the ACK cycle alone covers the whole delay.
            if (cnt_r == 4'd1) begin
              membus_rd_rs  <= 1'b1;
              membus_mb_out <= core[addr_r];
              state_r       <= RDHOLD;
            end else begin
              cnt_r   <= cnt_r - 4'd1;
              state_r <= RDWAIT;
            end
          end else begin
            state_r <= WRWAIT;
          end
        end
        RDWAIT: begin
          if (cnt_r == 4'd1) begin
            membus_rd_rs  <= 1'b1;
            membus_mb_out <= core[addr_r];
            state_r       <= RDHOLD;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            state_r <= RDWAIT;
          end
        end
        RDHOLD: begin
          if (wr_r) begin
            state_r <= WRWAIT;
          end else begin
            state_r <= DONE;
          end
`ifdef SRAM_TIMEOUT_EN
          tmo_r <= 10'd0;
`endif
        end
        WRWAIT: begin
          if (membus_wr_rs) begin
            state_r <= DONE;
`ifdef SRAM_TIMEOUT_EN
          end else if (tmo_r == 10'd1023) begin
            state_r <= DONE;
          end else begin
            tmo_r   <= tmo_r + 10'd1;
            state_r <= WRWAIT;
`else
          end else begin
            state_r <= WRWAIT;
`endif
          end
        end
        DONE: begin
          if (!membus_rq_cyc) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_mem.md
SRAM_MEM -- requirements
Module: sram_mem

Interface
REQ-001 The module SHALL have parameter SEL, default 4'o0: the membus_sel value this module answers to.
REQ-002 The module SHALL have parameter RD_DLY, default 4: cycles from addr_ack to rd_rs; legal range 1..15.
REQ-003 The module SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The module SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL provide port power  input  1  module enabled; while 0, no new cycle is accepted.
REQ-006 The module SHALL provide port membus_rq_cyc  input  1  processor requests a memory cycle.
REQ-007 The module SHALL provide port membus_rd_rq  input  1  read requested.
REQ-008 The module SHALL provide port membus_wr_rq  input  1  write requested (rd_rq and wr_rq both set = read-modify-write).
REQ-009 The module SHALL provide port membus_ma  input  15 [21:35]  word address; bits [22:35] index 16K words.
REQ-010 The module SHALL provide port membus_sel  input  4 [18:21]  module select.
REQ-011 The module SHALL provide port membus_fmc_select  input  1  fast memory selected; this module ignores cycles while it is 1.
REQ-012 The module SHALL provide port membus_wr_rs  input  1  write data on membus_mb_in valid, restart.
REQ-013 The module SHALL provide port membus_mb_in  input  36 [0:35]  write data.
REQ-014 The module SHALL provide port membus_mb_out  output  36 [0:35]  read data, ORed onto the bus; 0 when not driving.
REQ-015 The module SHALL provide port membus_addr_ack  output  1  address accepted, one-cycle pulse.
REQ-016 The module SHALL provide port membus_rd_rs  output  1  read data valid, one-cycle pulse.

Function
REQ-017 The module SHALL define its states as IDLE, ACK, RDWAIT, RDHOLD, WRWAIT, DONE.
REQ-018 The module SHALL enable a request when membus_rq_cyc, power, membus_sel==SEL and !membus_fmc_select all hold, and rd_rq or wr_rq is set.
REQ-019 On an enabled request, IDLE SHALL latch ma[22:35], rd_rq and wr_rq, then go to ACK.
REQ-020 ACK SHALL assert membus_addr_ack for exactly one cycle; the next state SHALL be RDWAIT if rd_rq was latched, else WRWAIT.
REQ-021 RDWAIT SHALL count RD_DLY cycles and read the word at the latched address.
REQ-022 When the RDWAIT count ends, membus_rd_rs SHALL pulse for one cycle, and the state SHALL go to RDHOLD.
REQ-023 In RDHOLD, membus_mb_out SHALL equal the read word; everywhere else membus_mb_out SHALL be 0.
REQ-024 RDHOLD SHALL go to WRWAIT if wr_rq was latched, else to DONE; on a plain read the memory content SHALL be unchanged.
REQ-025 WRWAIT SHALL, on membus_wr_rs=1, write membus_mb_in to the latched address in that cycle, then go to DONE.
REQ-026 DONE SHALL wait for membus_rq_cyc=0 and then return to IDLE, so a request held high is never serviced twice.
REQ-027 Changes to ma, sel, rd_rq or wr_rq after ACK SHALL be ignored.
REQ-028 A request while not in IDLE SHALL be ignored.
REQ-029 If membus_rq_cyc drops in RDWAIT or WRWAIT, the cycle SHALL complete through DONE anyway; no write occurs unless wr_rs is seen.
REQ-030 power falling mid-cycle SHALL NOT abort the current cycle.
REQ-031 Storage SHALL be 16384x36 words with no reset of contents, and SHALL be accessible hierarchically as array "core" for bench preload.

Reset
REQ-032 Reset low SHALL immediately force state IDLE, membus_addr_ack=0, membus_rd_rs=0, membus_mb_out=0, and clear the latches and the counter.
REQ-033 Reset SHALL leave memory contents unchanged; a write not yet performed when reset asserts is lost.

Configuration
REQ-034 With SRAM_TIMEOUT_EN defined, WRWAIT SHALL abort to DONE without writing if wr_rs is absent for 1024 cycles.
REQ-035 Without SRAM_TIMEOUT_EN, WRWAIT SHALL wait for wr_rs indefinitely.

Verification
REQ-036 Read test: preload core[0o105]=0o000000001234; read ma=0o105, sel=0 -> addr_ack 1 cycle after request, rd_rs RD_DLY cycles later, mb_out=0o1234 in RDHOLD, 0 after.
REQ-037 Write test: write ma=0o41, wr_rs with mb_in=0o777 -> core[0o41]=0o777; no rd_rs; mb_out stays 0.
REQ-038 Read-modify-write test: preload core[1]=5; rd+wr; after rd_rs, wr_rs with mb_in=6 -> mb_out=5 at rd_rs, core[1]=6.
REQ-039 Deselect test: sel=1 or fmc_select=1 or power=0 -> no addr_ack, memory untouched; rq_cyc held high after DONE -> no second ack.
REQ-040 Reset test: assert reset during RDWAIT -> outputs 0 at once; core unchanged; the next request is serviced normally.
REQ-041 Timeout test (SRAM_TIMEOUT_EN defined): write with no wr_rs -> back to IDLE after 1024 cycles plus rq_cyc drop, target word unchanged.
